mesm6_busarb: RTL
=================

MESM6_BUSARB -- requirements
Module: mesm6_busarb

Interface
REQ-001 Parameter TIMEOUT, default 255, SHALL be the maximum number of cycles to wait for mem_ready before aborting an access; legal range 1..1023.
REQ-002 clk  input  1  clock; all logic SHALL sample on the rising edge.
REQ-003 reset  input  1  reset, synchronous and active-high.
REQ-004 ibus_fetch  input  1  core instruction-fetch request, held until the ibus_done cycle.
REQ-005 ibus_addr  input  15  instruction word address.
REQ-006 ibus_input  output  48  fetched instruction word.
REQ-007 ibus_done  output  1  one-cycle fetch-completion pulse.
REQ-008 dbus_read, dbus_write  input  1 each  core data read and write requests, held until the dbus_done cycle.
REQ-009 dbus_addr  input  15  data word address.
REQ-010 dbus_output  input  48  write data from the core.
REQ-011 dbus_input  output  48  read data to the core.
REQ-012 dbus_done  output  1  one-cycle data-completion pulse.
REQ-013 mem_req  output  1  memory access strobe, held until mem_ready.
REQ-014 mem_we  output  1  memory write enable.
REQ-015 mem_addr  output  15  memory address.
REQ-016 mem_wdata  output  48  memory write data.
REQ-017 mem_rdata  input  48  memory read data, valid in the mem_ready cycle.
REQ-018 mem_ready  input  1  memory access completes in the current cycle.
REQ-019 bus_err  output  1  one-cycle pulse in the RESP cycle of an access that timed out.

Function
REQ-020 The block SHALL share one single-port memory between the instruction bus and the data bus using the FSM states IDLE, D_ACC, I_ACC and RESP.
REQ-021 IDLE: on data request (read|write) -> D_ACC; on fetch only -> I_ACC; otherwise stay. Data SHALL have priority over fetch.
REQ-022 D_ACC: mem_req=1, mem_addr=dbus_addr, mem_we=dbus_write, mem_wdata=dbus_output; on mem_ready -> I_ACC if ibus_fetch is asserted, else -> RESP.
REQ-023 I_ACC: mem_req=1, mem_we=0, mem_addr=ibus_addr; on mem_ready -> RESP.
REQ-024 RESP: dbus_done and ibus_done SHALL pulse for exactly one cycle, only for the buses served in this transaction, and the FSM SHALL then return to IDLE unconditionally.
REQ-025 Both dones SHALL be asserted in the same RESP cycle when both buses were requested, because the core stalls until both dones coincide.
REQ-026 mem_rdata SHALL be latched on mem_ready: into dbuf for a data read and into ibuf for a fetch. dbus_input=dbuf and ibus_input=ibuf, each stable until its next latch.
REQ-027 dbus_read and dbus_write asserted together SHALL perform a write only and leave dbuf unchanged.
REQ-028 Minimum latency with zero-wait memory SHALL be: request seen in cycle 0, access in cycle 1, done in cycle 2. A dual request with zero-wait memory SHALL complete with both dones in cycle 3.
REQ-029 mem_req SHALL be 0 in IDLE and RESP; at most one memory access SHALL be outstanding at a time.
REQ-030 A wait counter SHALL clear on entry to D_ACC or I_ACC and increment each cycle without mem_ready.
REQ-031 When the wait counter reaches TIMEOUT, the block SHALL treat the access as complete: read buffer loaded with 0, sticky abort flag set, normal next-state taken. bus_err SHALL pulse in RESP, and the flag SHALL clear in IDLE.
REQ-032 A request deasserted mid-access (not legal core behaviour) SHALL NOT abort the access; the corresponding done SHALL still pulse in RESP.
REQ-033 Requests asserted during RESP SHALL be ignored; they are re-evaluated in IDLE on the next cycle.

Reset
REQ-034 On reset: FSM=IDLE; mem_req, mem_we, ibus_done, dbus_done, bus_err=0; dbuf, ibuf=0; counter and flags=0.
REQ-035 Reset mid-access SHALL drop mem_req on the next edge with no done pulse; the memory SHALL tolerate an abandoned strobe.

Structure
REQ-036 The FSM state encoding, TIMEOUT default and counter width (10 bits) SHALL reside in mesm6_defines.sv alongside the other core constants.
REQ-037 No sub-module is required; the timeout counter SHALL be inline.

Verification
REQ-038 Zero-wait data read, addr 0x0123, mem_rdata=0x123456789ABC -> dbus_done in cycle 2, dbus_input=0x123456789ABC, ibus_done=0.
REQ-039 Simultaneous fetch 0x0010 and write 0x0200 data 0xFFFF00000001, mem_ready=1 -> write issued first, then fetch; ibus_done and dbus_done in the same cycle (cycle 3).
REQ-040 Fetch with mem_ready delayed 5 cycles -> mem_req held 6 cycles with stable addr; one ibus_done pulse, ibus_input matches.
REQ-041 TIMEOUT=8, mem_ready never asserted on a read -> after 8 wait cycles: RESP with dbus_done and bus_err, dbus_input=0.
REQ-042 Reset asserted in cycle 2 of a D_ACC wait -> mem_req=0 and FSM=IDLE after the next edge; no done pulses; the next request is served normally.
REQ-043 Back-to-back fetches held high across RESP -> exactly one ibus_done per transaction; the next access starts 1 cycle after RESP.

Source files
------------

// File: rtl/mesm6_defines.sv
// MESM-6 core constants: bus arbiter state encoding,
// access timeout default and wait counter width.
package mesm6_defines;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_D_ACC,
      ST_I_ACC,
      ST_RESP
   } arb_state_t;

   localparam int unsigned TIMEOUT_DEF = 255;
   localparam int CNT_W = 10;

endpackage

// File: rtl/mesm6_busarb.sv
// MESM-6 memory arbiter: shares one single-port memory
// between the instruction and data buses, data first.
module mesm6_busarb
   import mesm6_defines::*;
#(
   parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ibus_fetch,
   input  logic [14:0] ibus_addr,
   output logic [47:0] ibus_input,
   output logic        ibus_done,
   input  logic        dbus_read,
   input  logic        dbus_write,
   input  logic [14:0] dbus_addr,
   input  logic [47:0] dbus_output,
   output logic [47:0] dbus_input,
   output logic        dbus_done,
   output logic        mem_req,
   output logic        mem_we,
   output logic [14:0] mem_addr,
   output logic [47:0] mem_wdata,
   input  logic [47:0] mem_rdata,
   input  logic        mem_ready,
   output logic        bus_err
);

   arb_state_t       state, state_nx;
   logic [CNT_W-1:0] cnt;
   logic             abort;
   logic             d_srv, i_srv;
   logic [47:0]      dbuf, ibuf;
   logic             tmo, acc_done;
   logic [47:0]      rdata;

   // A timed-out access completes with zero read data.
   assign tmo      = !mem_ready && (cnt == CNT_W'(TIMEOUT));
   assign acc_done = mem_ready || tmo;
   assign rdata    = tmo ? 48'd0 : mem_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         cnt   <= '0;
         abort <= 1'b0;
         d_srv <= 1'b0;
         i_srv <= 1'b0;
         dbuf  <= '0;
         ibuf  <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            ST_IDLE: begin
               cnt   <= '0;
               abort <= 1'b0;
               d_srv <= dbus_read | dbus_write;
               i_srv <= ibus_fetch & ~(dbus_read | dbus_write);
            end
            ST_D_ACC: begin
               if (acc_done) begin
                  cnt <= '0;
                  if (tmo)
                     abort <= 1'b1;
                  if (!dbus_write)
                     dbuf <= rdata;
                  if (ibus_fetch)
                     i_srv <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_I_ACC: begin
               if (acc_done) begin
                  if (tmo)
                     abort <= 1'b1;
                  ibuf <= rdata;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            ST_RESP: begin
            end
         endcase
      end
   end

   always_comb begin
      state_nx  = state;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      unique case (state)
         ST_IDLE: begin
            if (dbus_read || dbus_write)
               state_nx = ST_D_ACC;
            else if (ibus_fetch)
               state_nx = ST_I_ACC;
         end
         ST_D_ACC: begin
            mem_req   = 1'b1;
            mem_we    = dbus_write;
            mem_addr  = dbus_addr;
            mem_wdata = dbus_output;
            if (acc_done)
               state_nx = ibus_fetch ? ST_I_ACC : ST_RESP;
         end
         ST_I_ACC: begin
            mem_req  = 1'b1;
            mem_addr = ibus_addr;
            if (acc_done)
               state_nx = ST_RESP;
         end
         ST_RESP: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   assign dbus_done  = (state == ST_RESP) && d_srv;
   assign ibus_done  = (state == ST_RESP) && i_srv;
   assign bus_err    = (state == ST_RESP) && abort;
   assign dbus_input = dbuf;
   assign ibus_input = ibuf;

endmodule
